// File: rtl/cortex_m0_pkg.sv
// Shared definitions for the Cortex-M0 style front end: default widths,
// reset vector and the fetch sequencer state encoding.
package cortex_m0_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer (master) and the fetch/decode
// logic (slave) that accepts addresses and reports control-flow events.
interface pc_sequencer_if import cortex_m0_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              stall;
  logic              fetch_ready;
  logic              instr_size;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              call;
  logic              ret;
  logic              exc_req;
  logic [ADDR_W-1:0] exc_vector;
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    input  stall, fetch_ready, instr_size, branch_taken, branch_target,
    input  call, ret, exc_req, exc_vector,
    output pc, pc_valid, ras_empty, ras_full, ras_err
  );

  modport slave (
    output stall, fetch_ready, instr_size, branch_taken, branch_target,
    output call, ret, exc_req, exc_vector,
    input  pc, pc_valid, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing onto a full stack overwrites the
// oldest entry, so only the newest DEPTH return addresses are kept.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign top_idx   = ptr_q - PTR_W'(1);
  assign top       = mem_q[top_idx];
  assign overflow  = push & ~pop & full;
  assign underflow = pop & ~push & empty;

  // ptr_q is the next write slot; it wraps naturally because DEPTH is a power of 2
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && !pop) begin
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (pop && !push && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential Thumb advance, prioritised redirects
// (exception > return > branch) and a return-address stack for calls.
module pc_sequencer import cortex_m0_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter int                RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.master bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, seq_pc, ras_top;
  logic              pc_valid_q, pc_valid_d;
  logic              ras_err_q, ras_err_d;
  logic              adv, redirect, push, pop;
  logic              ras_empty, ras_full, ras_overflow, ras_underflow;

  function automatic logic [ADDR_W-1:0] clr_lsb(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (clr_lsb(seq_pc)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // Redirects override stall/fetch_ready; only a plain advance depends on acceptance
  always_comb begin
    adv      = pc_valid_q & bus.fetch_ready & ~bus.stall;
    pc_inc   = bus.instr_size ? ADDR_W'(4) : ADDR_W'(2);
    seq_pc   = pc_q + pc_inc;
    pc_d     = pc_q;
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (bus.exc_req) begin
      redirect = 1'b1;
      pc_d     = clr_lsb(bus.exc_vector);
    end else if (bus.ret) begin
      redirect = 1'b1;
      pop      = 1'b1;
      pc_d     = ras_empty ? clr_lsb(bus.branch_target) : clr_lsb(ras_top);
    end else if (bus.branch_taken) begin
      redirect = 1'b1;
      push     = bus.call;
      pc_d     = clr_lsb(bus.branch_target);
    end else if (adv) begin
      pc_d = seq_pc;
    end

    ras_err_d = ras_err_q | ras_overflow | ras_underflow;

    state_d = state_q;
    case (state_q)
      BOOT:    state_d = redirect ? BUBBLE : RUN;
      RUN:     state_d = redirect ? BUBBLE : RUN;
      BUBBLE:  state_d = redirect ? BUBBLE : RUN;
      default: state_d = BOOT;
    endcase
    pc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      ras_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ras_err_q  <= ras_err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = pc_valid_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_err   = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit default instance plus an 8-bit
// instance with a non-zero reset vector for wrap and mid-bubble reset.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  logic rst8;
  int   tests_run;
  int   tests_failed;

  pc_sequencer_if #(.ADDR_W(32)) bus ();
  pc_sequencer_if #(.ADDR_W(8))  bus8 ();

  pc_sequencer #(
    .ADDR_W    (32),
    .RESET_VEC (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_sequencer #(
    .ADDR_W    (8),
    .RESET_VEC (8'h20),
    .RAS_DEPTH (4)
  ) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.fetch_ready   = 1'b1;
    bus.instr_size    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.exc_req       = 1'b0;
    bus.exc_vector    = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    tests_run++;
    if (bus.pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc: got %h expected %h", bus.pc, 32'h0);
    end
    tests_run++;
    if ({bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_err} !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags(valid,empty,full,err): got %b expected %b",
               {bus.pc_valid, bus.ras_empty, bus.ras_full, bus.ras_err}, 4'b0100);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("[TB] FAIL boot_to_run: got valid=%b pc=%h expected valid=1 pc=%h",
               bus.pc_valid, bus.pc, 32'h0);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h2, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      bus.instr_size = (i == 2);
      tick();
      tests_run++;
      if (bus.pc !== exp_pc[i]) begin
        tests_failed++;
        $display("[TB] FAIL seq_step%0d: got %h expected %h", i, bus.pc, exp_pc[i]);
      end
    end
    bus.instr_size = 1'b0;
  endtask

  task automatic test_stall();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h10;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b0, 32'h10}) begin
      tests_failed++;
      $display("[TB] FAIL stall_branch: got valid=%b pc=%h expected valid=0 pc=%h",
               bus.pc_valid, bus.pc, 32'h10);
    end
    bus.branch_taken = 1'b0;
    bus.stall        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if ({bus.pc_valid, bus.pc} !== {1'b1, 32'h10}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                 i, bus.pc_valid, bus.pc, 32'h10);
      end
    end
    bus.stall = 1'b0;
    tick();
    tests_run++;
    if (bus.pc !== 32'h12) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got %h expected %h", bus.pc, 32'h12);
    end
  endtask

  task automatic test_call_ret();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    bus.branch_taken = 1'b0;
    tick();
    bus.instr_size    = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.call          = 1'b1;
    bus.branch_target = 32'h201;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.ras_empty, bus.pc} !== {2'b00, 32'h200}) begin
      tests_failed++;
      $display("[TB] FAIL call_redirect: got valid=%b empty=%b pc=%h expected valid=0 empty=0 pc=%h",
               bus.pc_valid, bus.ras_empty, bus.pc, 32'h200);
    end
    clear_inputs();
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b1, 32'h200}) begin
      tests_failed++;
      $display("[TB] FAIL call_run: got valid=%b pc=%h expected valid=1 pc=%h",
               bus.pc_valid, bus.pc, 32'h200);
    end
    bus.ret = 1'b1;
    tick();
    tests_run++;
    if ({bus.ras_empty, bus.ras_err, bus.pc} !== {2'b10, 32'h104}) begin
      tests_failed++;
      $display("[TB] FAIL ret_return: got empty=%b err=%b pc=%h expected empty=1 err=0 pc=%h",
               bus.ras_empty, bus.ras_err, bus.pc, 32'h104);
    end
    bus.ret = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h501;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b0, 32'h500}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got valid=%b pc=%h expected valid=0 pc=%h",
               bus.pc_valid, bus.pc, 32'h500);
    end
    bus.branch_target = 32'h600;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b0, 32'h600}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got valid=%b pc=%h expected valid=0 pc=%h",
               bus.pc_valid, bus.pc, 32'h600);
    end
    bus.branch_taken = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b1, 32'h602}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_resume: got valid=%b pc=%h expected valid=1 pc=%h",
               bus.pc_valid, bus.pc, 32'h602);
    end
    bus.call = 1'b1;
    tick();
    tests_run++;
    if ({bus.ras_empty, bus.pc} !== {1'b1, 32'h604}) begin
      tests_failed++;
      $display("[TB] FAIL call_no_branch: got empty=%b pc=%h expected empty=1 pc=%h",
               bus.ras_empty, bus.pc, 32'h604);
    end
    bus.call        = 1'b0;
    bus.fetch_ready = 1'b0;
    tick();
    tests_run++;
    if (bus.pc !== 32'h604) begin
      tests_failed++;
      $display("[TB] FAIL not_ready_hold: got %h expected %h", bus.pc, 32'h604);
    end
    bus.fetch_ready = 1'b1;
  endtask

  task automatic test_overflow();
    logic [31:0] tgt;
    logic [31:0] exp_ret;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tgt               = 32'h100 * k;
      bus.branch_taken  = 1'b1;
      bus.call          = 1'b1;
      bus.branch_target = tgt;
      tick();
      tests_run++;
      if (bus.pc !== tgt) begin
        tests_failed++;
        $display("[TB] FAIL ovf_call%0d: got %h expected %h", k, bus.pc, tgt);
      end
      if (k == 4) begin
        tests_run++;
        if ({bus.ras_full, bus.ras_err} !== 2'b10) begin
          tests_failed++;
          $display("[TB] FAIL ovf_full_no_err: got full,err=%b expected %b",
                   {bus.ras_full, bus.ras_err}, 2'b10);
        end
      end
    end
    tests_run++;
    if ({bus.ras_full, bus.ras_err} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL ovf_err: got full,err=%b expected %b",
               {bus.ras_full, bus.ras_err}, 2'b11);
    end
    bus.branch_taken  = 1'b0;
    bus.call          = 1'b0;
    bus.branch_target = 32'h777;
    bus.ret           = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      exp_ret = 32'h100 * k + 32'h2;
      tick();
      tests_run++;
      if (bus.pc !== exp_ret) begin
        tests_failed++;
        $display("[TB] FAIL ovf_ret%0d: got %h expected %h", k, bus.pc, exp_ret);
      end
    end
    tests_run++;
    if ({bus.ras_empty, bus.ras_full} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL ovf_drained: got empty,full=%b expected %b",
               {bus.ras_empty, bus.ras_full}, 2'b10);
    end
    tick();
    tests_run++;
    if ({bus.ras_err, bus.pc} !== {1'b1, 32'h776}) begin
      tests_failed++;
      $display("[TB] FAIL underflow_ret: got err=%b pc=%h expected err=1 pc=%h",
               bus.ras_err, bus.pc, 32'h776);
    end
    bus.ret = 1'b0;
  endtask

  task automatic test_exception();
    do_reset();
    bus.branch_taken  = 1'b1;
    bus.call          = 1'b1;
    bus.branch_target = 32'h300;
    tick();
    clear_inputs();
    tick();
    bus.exc_req       = 1'b1;
    bus.ret           = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h900;
    bus.exc_vector    = 32'h40;
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.ras_empty, bus.pc} !== {2'b00, 32'h40}) begin
      tests_failed++;
      $display("[TB] FAIL exc_entry: got valid=%b empty=%b pc=%h expected valid=0 empty=0 pc=%h",
               bus.pc_valid, bus.ras_empty, bus.pc, 32'h40);
    end
    clear_inputs();
    tick();
    tests_run++;
    if ({bus.pc_valid, bus.pc} !== {1'b1, 32'h40}) begin
      tests_failed++;
      $display("[TB] FAIL exc_run: got valid=%b pc=%h expected valid=1 pc=%h",
               bus.pc_valid, bus.pc, 32'h40);
    end
    bus.ret = 1'b1;
    tick();
    tests_run++;
    if ({bus.ras_empty, bus.ras_err, bus.pc} !== {2'b10, 32'h2}) begin
      tests_failed++;
      $display("[TB] FAIL exc_ras_kept: got empty=%b err=%b pc=%h expected empty=1 err=0 pc=%h",
               bus.ras_empty, bus.ras_err, bus.pc, 32'h2);
    end
    bus.ret = 1'b0;
  endtask

  task automatic test_wrap8();
    rst8 = 1'b0;
    tests_run++;
    if ({bus8.pc_valid, bus8.pc} !== {1'b0, 8'h20}) begin
      tests_failed++;
      $display("[TB] FAIL w8_reset: got valid=%b pc=%h expected valid=0 pc=%h",
               bus8.pc_valid, bus8.pc, 8'h20);
    end
    tick();
    bus8.branch_taken  = 1'b1;
    bus8.branch_target = 8'hFF;
    tick();
    bus8.branch_taken = 1'b0;
    tick();
    tests_run++;
    if ({bus8.pc_valid, bus8.pc} !== {1'b1, 8'hFE}) begin
      tests_failed++;
      $display("[TB] FAIL w8_at_fe: got valid=%b pc=%h expected valid=1 pc=%h",
               bus8.pc_valid, bus8.pc, 8'hFE);
    end
    bus8.instr_size = 1'b1;
    tick();
    tests_run++;
    if (bus8.pc !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL w8_wrap: got %h expected %h", bus8.pc, 8'h02);
    end
    bus8.instr_size    = 1'b0;
    bus8.branch_taken  = 1'b1;
    bus8.call          = 1'b1;
    bus8.branch_target = 8'h80;
    tick();
    bus8.branch_taken = 1'b0;
    bus8.call         = 1'b0;
    #3;
    rst8 = 1'b1;
    #1;
    tests_run++;
    if ({bus8.pc_valid, bus8.ras_empty, bus8.pc} !== {2'b01, 8'h20}) begin
      tests_failed++;
      $display("[TB] FAIL w8_mid_bubble_rst: got valid=%b empty=%b pc=%h expected valid=0 empty=1 pc=%h",
               bus8.pc_valid, bus8.ras_empty, bus8.pc, 8'h20);
    end
    rst8 = 1'b0;
    tick();
    tests_run++;
    if ({bus8.pc_valid, bus8.pc} !== {1'b1, 8'h20}) begin
      tests_failed++;
      $display("[TB] FAIL w8_boot_run: got valid=%b pc=%h expected valid=1 pc=%h",
               bus8.pc_valid, bus8.pc, 8'h20);
    end
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    rst                = 1'b1;
    rst8               = 1'b1;
    bus8.stall         = 1'b0;
    bus8.fetch_ready   = 1'b1;
    bus8.instr_size    = 1'b0;
    bus8.branch_taken  = 1'b0;
    bus8.branch_target = 8'h0;
    bus8.call          = 1'b0;
    bus8.ret           = 1'b0;
    bus8.exc_req       = 1'b0;
    bus8.exc_vector    = 8'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_call_ret();
    test_back_to_back();
    test_overflow();
    test_exception();
    test_wrap8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, PC and target width in bits (min 8).
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset; bit 0 SHALL be 0.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, 2..16).
REQ-004 One clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-005 stall  input  1  hold PC, no sequential advance.
REQ-006 fetch_ready  input  1  fetch stage accepts current pc.
REQ-007 instr_size  input  1  size of accepted instruction: 0 = 2 bytes (Thumb-16), 1 = 4 bytes (Thumb-32/BL).
REQ-008 branch_taken  input  1  redirect to branch_target.
REQ-009 branch_target  input  ADDR_W  branch destination.
REQ-010 call  input  1  with branch_taken: push return address (BL/BLX).
REQ-011 ret  input  1  redirect to RAS top (BX LR / POP PC).
REQ-012 exc_req  input  1  exception entry redirect.
REQ-013 exc_vector  input  ADDR_W  exception handler address.
REQ-014 pc  output  ADDR_W  current fetch address.
REQ-015 pc_valid  output  1  pc is a valid fetch request.
REQ-016 ras_empty / ras_full  output  1 each  RAS occupancy flags.
REQ-017 ras_err  output  1  sticky: RAS overflow or underflow occurred.

Function
REQ-018 FSM states: BOOT, RUN, BUBBLE; pc_valid = 1 only in RUN.
REQ-019 BOOT -> RUN after exactly one cycle; RUN -> BUBBLE on any redirect; BUBBLE -> RUN after one cycle unless another redirect arrives (stays BUBBLE).
REQ-020 Accept: adv = pc_valid & fetch_ready & !stall.
REQ-021 On adv with no redirect: pc <= pc + (instr_size ? 4 : 2), modulo 2^ADDR_W (wrap from all-ones region to 0, no flag).
REQ-022 Redirect priority: exc_req > ret > branch_taken > sequential; redirects act in any state, regardless of stall or fetch_ready.
REQ-023 Every redirect target has bit 0 forced to 0 before loading pc.
REQ-024 exc_req: pc <= exc_vector; RAS untouched; call/ret/branch ignored that cycle.
REQ-025 ret, RAS non-empty: pc <= top entry, pop; RAS empty: pc <= branch_target, set ras_err.
REQ-026 ret and call in the same cycle: ret wins, no push.
REQ-027 branch_taken & call (no ret/exc): push pc + (instr_size ? 4 : 2) with bit 0 cleared, pc <= branch_target.
REQ-028 Push when full: oldest entry discarded (circular), depth stays RAS_DEPTH, ras_err set.
REQ-029 call without branch_taken has no effect.
REQ-030 In BOOT or BUBBLE, non-redirect cycles hold pc.
REQ-031 ras_err clears only on reset.

Reset
REQ-032 On rst: pc = RESET_VEC, state = BOOT, pc_valid = 0, RAS empty (ras_empty = 1, ras_full = 0), ras_err = 0.
REQ-033 Reset asserted mid-redirect or mid-push abandons the operation; no partial RAS update survives.

Structure
REQ-034 Shared package cortex_m0_pkg holds: ADDR_W default, RESET_VEC default, FSM state enum (BOOT/RUN/BUBBLE).
REQ-035 RAS implemented as sub-module ras_stack (push, pop, din, top, empty, full, overflow, underflow; circular pointer + count).
REQ-036 pc register, FSM, increment and priority mux live in pc_sequencer; no combinational path from fetch_ready to pc.

Verification
REQ-037 Reset release, fetch_ready=1, instr_size=0: pc_valid=0 one cycle at 0x0, then pc = 0x0, 0x2, 0x4; instr_size=1 next step -> 0x8.
REQ-038 stall=1 three cycles at pc=0x10: pc holds 0x10, pc_valid=1; stall released -> 0x12.
REQ-039 At pc=0x100, instr_size=1, branch_taken=call=1, target 0x201: pc=0x200 after one BUBBLE cycle, RAS top 0x104; ret later -> pc=0x104, ras_empty=1.
REQ-040 Push 5 calls with RAS_DEPTH=4: ras_full=1, ras_err=1, four rets return newest four addresses in LIFO order, fifth ret with empty RAS goes to branch_target.
REQ-041 exc_req, ret and branch_taken same cycle, exc_vector=0x40: pc=0x40, RAS unchanged, pc_valid low one cycle.
REQ-042 ADDR_W=8, pc=0xFE, instr_size=1: next pc=0x02; rst mid-BUBBLE -> pc=RESET_VEC, BOOT.
